// File: rtl/regfile_wb_arbiter_if.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter_if
//
// Bundles every non-clock signal of the register-file writeback arbiter.
//
//   ALU writeback port : alu_valid, alu_rd, alu_data   -> alu_ready
//   LSU writeback port : lsu_valid, lsu_rd, lsu_data   -> lsu_ready
//   Regfile write port : rd_we, writeReg, writeData       (arbiter output)
//   Scoreboard         : issue_valid, issue_rd            (mark busy)
//                        chk_rs1, chk_rs2 -> rs1_busy, rs2_busy
//   Statistics         : conflict_cnt
//
// Modports:
//   master - the pipeline side (drives requests, issue and hazard queries)
//   slave  - the arbiter itself
// ---------------------------------------------------------------------------
interface regfile_wb_arbiter_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) ();

  // ALU writeback request
  logic             alu_valid;
  logic [4:0]       alu_rd;
  logic [XLEN-1:0]  alu_data;
  logic             alu_ready;

  // Load-unit writeback request
  logic             lsu_valid;
  logic [4:0]       lsu_rd;
  logic [XLEN-1:0]  lsu_data;
  logic             lsu_ready;

  // Registered regfile write port
  logic             rd_we;
  logic [4:0]       writeReg;
  logic [XLEN-1:0]  writeData;

  // Scoreboard set / query
  logic             issue_valid;
  logic [4:0]       issue_rd;
  logic [4:0]       chk_rs1;
  logic [4:0]       chk_rs2;
  logic             rs1_busy;
  logic             rs2_busy;

  // Number of cycles in which both requesters competed
  logic [CNT_W-1:0] conflict_cnt;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output lsu_valid, lsu_rd, lsu_data,
    output issue_valid, issue_rd, chk_rs1, chk_rs2,
    input  alu_ready, lsu_ready,
    input  rd_we, writeReg, writeData,
    input  rs1_busy, rs2_busy, conflict_cnt
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  lsu_valid, lsu_rd, lsu_data,
    input  issue_valid, issue_rd, chk_rs1, chk_rs2,
    output alu_ready, lsu_ready,
    output rd_we, writeReg, writeData,
    output rs1_busy, rs2_busy, conflict_cnt
  );

endinterface

// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Merges the ALU and load-unit writeback streams onto the single regfile
// write port and tracks which architectural registers still have a write
// in flight.
//
// Ports:
//   clk  - single clock, all state updates on the rising edge
//   rst  - asynchronous, active-high reset
//   bus  - regfile_wb_arbiter_if.slave (requests, write port, scoreboard,
//          conflict counter; see the interface file for the signal list)
//
// Behaviour summary:
//   * ready is combinational from the two valids and a round-robin pointer;
//     at most one ready is high, and none while rst is high.
//   * An accepted request is registered onto rd_we/writeReg/writeData at the
//     same edge (1-cycle latency, one write per cycle sustained). Writes to
//     x0 are accepted but leave rd_we low.
//   * The pointer moves to the other source after every accepted transfer,
//     so a loser of one conflict is guaranteed to win the next.
//   * Busy bits are set by issue and cleared by the committing write; a
//     simultaneous set and clear of the same register leaves it busy.
//   * conflict_cnt counts cycles with both valids high and saturates.
// ---------------------------------------------------------------------------
module regfile_wb_arbiter #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  regfile_wb_arbiter_if.slave    bus
);

  // Round-robin pointer: names the source that wins the next conflict.
  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSU = 1'b1
  } src_e;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  src_e             ptr_q,   ptr_d;
  logic             rd_we_q, rd_we_d;
  logic [4:0]       wreg_q,  wreg_d;
  logic [XLEN-1:0]  wdata_q, wdata_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [31:0]      busy_q,  busy_d;

  // -------------------------------------------------------------------------
  // Arbitration
  // -------------------------------------------------------------------------
  logic            both_valid;
  logic            alu_grant;
  logic            lsu_grant;
  logic            xfer;
  logic [4:0]      sel_rd;
  logic [XLEN-1:0] sel_data;

  assign both_valid = bus.alu_valid & bus.lsu_valid;

  // A lone requester always wins; on a conflict the pointer decides.
  // Reset masks both grants so nothing is accepted while rst is high.
  assign alu_grant = ~rst & bus.alu_valid & (~bus.lsu_valid | (ptr_q == SRC_ALU));
  assign lsu_grant = ~rst & bus.lsu_valid & (~bus.alu_valid | (ptr_q == SRC_LSU));
  assign xfer      = alu_grant | lsu_grant;

  assign bus.alu_ready = alu_grant;
  assign bus.lsu_ready = lsu_grant;

  // Grants are mutually exclusive, so a two-way mux is enough.
  assign sel_rd   = lsu_grant ? bus.lsu_rd   : bus.alu_rd;
  assign sel_data = lsu_grant ? bus.lsu_data : bus.alu_data;

  always_comb begin
    ptr_d   = ptr_q;
    rd_we_d = 1'b0;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;

    if (xfer) begin
      // Hand the next conflict to whichever source did not just win.
      ptr_d   = lsu_grant ? SRC_ALU : SRC_LSU;
      // x0 writes are consumed but never reach the regfile; the address and
      // data registers still follow the accepted request.
      rd_we_d = (sel_rd != 5'd0);
      wreg_d  = sel_rd;
      wdata_d = sel_data;
    end
  end

  // -------------------------------------------------------------------------
  // Conflict counter (saturating)
  // -------------------------------------------------------------------------
  always_comb begin
    cnt_d = cnt_q;
    if (both_valid && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Scoreboard
  //
  // The clear comes from the registered write port: the regfile commits the
  // write at the edge where rd_we is high, so that same edge retires the
  // pending entry. Set is OR-ed in after the clear so a new issue to the
  // register being retired keeps it busy.
  // -------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_busy
      if (gi == 0) begin : g_zero
        // x0 is never a real destination, so it can never be pending.
        assign busy_d[gi] = 1'b0;
      end else begin : g_reg
        logic set_hit;
        logic clr_hit;

        assign set_hit    = bus.issue_valid & (bus.issue_rd == 5'(gi));
        assign clr_hit    = rd_we_q & (wreg_q == 5'(gi));
        assign busy_d[gi] = set_hit | (busy_q[gi] & ~clr_hit);
      end
    end
  endgenerate

  // No bypass: a write committing this cycle still reports busy until the
  // edge has retired it.
  assign bus.rs1_busy = busy_q[bus.chk_rs1];
  assign bus.rs2_busy = busy_q[bus.chk_rs2];

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q   <= SRC_ALU;
      rd_we_q <= 1'b0;
      wreg_q  <= 5'd0;
      wdata_q <= '0;
      cnt_q   <= '0;
      busy_q  <= '0;
    end else begin
      ptr_q   <= ptr_d;
      rd_we_q <= rd_we_d;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.rd_we        = rd_we_q;
  assign bus.writeReg     = wreg_q;
  assign bus.writeData    = wdata_q;
  assign bus.conflict_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_wb_arbiter
//
// Self-checking bench: a directed vector table, hand-written sequences for
// reset and scoreboard corner cases, then randomized traffic compared with a
// transaction-level reference model. The counter width is reduced so that
// saturation is reached during the random phase.
// ---------------------------------------------------------------------------
module tb_regfile_wb_arbiter;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk;
  logic rst;

  regfile_wb_arbiter_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

  regfile_wb_arbiter #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.alu_valid   = 1'b0;
    bus.alu_rd      = 5'd0;
    bus.alu_data    = '0;
    bus.lsu_valid   = 1'b0;
    bus.lsu_rd      = 5'd0;
    bus.lsu_data    = '0;
    bus.issue_valid = 1'b0;
    bus.issue_rd    = 5'd0;
    bus.chk_rs1     = 5'd0;
    bus.chk_rs2     = 5'd0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Directed vector: inputs for one cycle, expected readies during that
  // cycle and expected write port / counter after the edge.
  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [31:0] adat;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ldat;
    logic        exp_ar;
    logic        exp_lr;
    logic        exp_we;
    logic [4:0]  exp_reg;
    logic [31:0] exp_data;
    logic [3:0]  exp_cnt;
  } vec_t;

  vec_t vecs[9];

  // Reference model state
  bit          m_next_alu;   // ALU wins the next conflict
  logic        m_we;
  logic [4:0]  m_reg;
  logic [31:0] m_data;
  int          m_cnt;
  bit          m_busy[32];

  task automatic model_reset();
    m_next_alu = 1'b1;
    m_we       = 1'b0;
    m_reg      = 5'd0;
    m_data     = '0;
    m_cnt      = 0;
    for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
  endtask

  initial begin
    bit          alu_hold;
    bit          lsu_hold;
    logic        exp_ar;
    logic        exp_lr;
    logic        n_we;
    logic [4:0]  n_reg;
    logic [31:0] n_data;
    bit          n_next_alu;
    int          n_cnt;
    bit          n_busy[32];
    logic        e_rs1;
    logic        e_rs2;

    rst = 1'b0;
    idle_inputs();

    vecs[0] = '{1'b1, 5'd5,  32'hA5A5A5A5, 1'b0, 5'd0, 32'h0,
                1'b1, 1'b0, 1'b1, 5'd5,  32'hA5A5A5A5, 4'd0};
    vecs[1] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,
                1'b0, 1'b0, 1'b0, 5'd5,  32'hA5A5A5A5, 4'd0};
    vecs[2] = '{1'b1, 5'd10, 32'h12345678, 1'b1, 5'd7, 32'hDEADBEEF,
                1'b0, 1'b1, 1'b1, 5'd7,  32'hDEADBEEF, 4'd1};
    vecs[3] = '{1'b1, 5'd10, 32'h12345678, 1'b1, 5'd7, 32'hDEADBEEF,
                1'b1, 1'b0, 1'b1, 5'd10, 32'h12345678, 4'd2};
    vecs[4] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0, 32'hFFFFFFFF,
                1'b0, 1'b1, 1'b0, 5'd0,  32'hFFFFFFFF, 4'd2};
    vecs[5] = '{1'b1, 5'd31, 32'h00000001, 1'b0, 5'd0, 32'h0,
                1'b1, 1'b0, 1'b1, 5'd31, 32'h00000001, 4'd2};
    vecs[6] = '{1'b1, 5'd2,  32'h00000002, 1'b0, 5'd0, 32'h0,
                1'b1, 1'b0, 1'b1, 5'd2,  32'h00000002, 4'd2};
    vecs[7] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd9, 32'h00000099,
                1'b0, 1'b1, 1'b1, 5'd9,  32'h00000099, 4'd2};
    vecs[8] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,
                1'b0, 1'b0, 1'b0, 5'd9,  32'h00000099, 4'd2};

    // ---- Asynchronous reset from power-up, valids held high -------------
    bus.alu_valid = 1'b1;
    bus.lsu_valid = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("rst_rd_we",     bus.rd_we,        0);
    check("rst_writeReg",  bus.writeReg,     0);
    check("rst_writeData", bus.writeData,    0);
    check("rst_cnt",       bus.conflict_cnt, 0);
    check("rst_alu_ready", bus.alu_ready,    0);
    check("rst_lsu_ready", bus.lsu_ready,    0);
    check("rst_rs1_busy",  bus.rs1_busy,     0);
    tick();
    check("rst_hold_rd_we", bus.rd_we,        0);
    check("rst_hold_cnt",   bus.conflict_cnt, 0);
    idle_inputs();
    tick();
    rst = 1'b0;
    $display("reset: checked power-up state");

    // ---- Directed vector table ------------------------------------------
    apply_reset();
    for (int v = 0; v < 9; v++) begin
      bus.alu_valid = vecs[v].av;
      bus.alu_rd    = vecs[v].ard;
      bus.alu_data  = vecs[v].adat;
      bus.lsu_valid = vecs[v].lv;
      bus.lsu_rd    = vecs[v].lrd;
      bus.lsu_data  = vecs[v].ldat;
      @(negedge clk);
      check($sformatf("vec%0d_alu_ready", v), bus.alu_ready, vecs[v].exp_ar);
      check($sformatf("vec%0d_lsu_ready", v), bus.lsu_ready, vecs[v].exp_lr);
      tick();
      check($sformatf("vec%0d_rd_we", v),     bus.rd_we,        vecs[v].exp_we);
      check($sformatf("vec%0d_writeReg", v),  bus.writeReg,     vecs[v].exp_reg);
      check($sformatf("vec%0d_writeData", v), bus.writeData,    vecs[v].exp_data);
      check($sformatf("vec%0d_cnt", v),       bus.conflict_cnt, vecs[v].exp_cnt);
      $display("vec %0d: we=%0b reg=%0d data=%h cnt=%0d",
               v, bus.rd_we, bus.writeReg, bus.writeData, bus.conflict_cnt);
    end
    idle_inputs();

    // ---- Conflict straight after reset: ALU first, then LSU --------------
    apply_reset();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd10; bus.alu_data = 32'h12345678;
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd7;  bus.lsu_data = 32'hDEADBEEF;
    tick();
    check("conf1_writeReg",  bus.writeReg,  10);
    check("conf1_writeData", bus.writeData, 32'h12345678);
    tick();
    check("conf2_writeReg",  bus.writeReg,  7);
    check("conf2_writeData", bus.writeData, 32'hDEADBEEF);
    check("conf2_rd_we",     bus.rd_we,     1);
    check("conf2_cnt",       bus.conflict_cnt, 2);
    idle_inputs();
    tick();
    check("conf_idle_rd_we", bus.rd_we, 0);
    $display("seq conflict: two writes, cnt=%0d", bus.conflict_cnt);

    // ---- Scoreboard: set, no bypass, set-wins, clear ---------------------
    apply_reset();
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd3;
    bus.chk_rs1 = 5'd3;     bus.chk_rs2 = 5'd0;
    @(negedge clk);
    check("sb_before_set", bus.rs1_busy, 0);
    tick();
    bus.issue_valid = 1'b0;
    check("sb_set_rs1", bus.rs1_busy, 1);
    check("sb_x0_rs2",  bus.rs2_busy, 0);
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 32'h33;
    tick();
    check("sb_wb_rd_we",    bus.rd_we,    1);
    check("sb_wb_writeReg", bus.writeReg, 3);
    check("sb_no_bypass",   bus.rs1_busy, 1);
    // Re-issue x3 in the cycle the write commits: must stay busy.
    bus.alu_valid = 1'b0;
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd3;
    tick();
    bus.issue_valid = 1'b0;
    check("sb_set_wins", bus.rs1_busy, 1);
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 32'h44;
    tick();
    bus.alu_valid = 1'b0;
    check("sb_wb2_busy", bus.rs1_busy, 1);
    tick();
    check("sb_cleared", bus.rs1_busy, 0);
    $display("seq scoreboard: x3 busy=%0b", bus.rs1_busy);

    // ---- Reset mid-operation ---------------------------------------------
    idle_inputs();
    apply_reset();
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd3; bus.chk_rs1 = 5'd3;
    tick();
    bus.issue_valid = 1'b0;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd4; bus.alu_data = 32'h4;
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd6; bus.lsu_data = 32'h6;
    tick();
    check("mid_pre_rd_we", bus.rd_we,    1);
    check("mid_pre_busy",  bus.rs1_busy, 1);
    check("mid_pre_cnt",   bus.conflict_cnt, 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_rd_we",  bus.rd_we,        0);
    check("mid_rst_busy",   bus.rs1_busy,     0);
    check("mid_rst_cnt",    bus.conflict_cnt, 0);
    check("mid_rst_aready", bus.alu_ready,    0);
    check("mid_rst_lready", bus.lsu_ready,    0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.alu_rd = 5'd8; bus.alu_data = 32'h8;
    bus.lsu_rd = 5'd9; bus.lsu_data = 32'h9;
    @(negedge clk);
    check("post_rst_alu_ready", bus.alu_ready, 1);
    check("post_rst_lsu_ready", bus.lsu_ready, 0);
    tick();
    check("post_rst_writeReg", bus.writeReg, 8);
    $display("seq mid-reset: first winner reg=%0d", bus.writeReg);

    // ---- Randomized traffic vs reference model ---------------------------
    idle_inputs();
    apply_reset();
    model_reset();
    alu_hold = 1'b0;
    lsu_hold = 1'b0;
    for (int c = 0; c < 400; c++) begin
      // A losing requester must keep its request unchanged.
      if (!alu_hold) begin
        bus.alu_valid = ($urandom_range(0, 99) < 60);
        bus.alu_rd    = 5'($urandom_range(0, 31));
        bus.alu_data  = $urandom;
      end
      if (!lsu_hold) begin
        bus.lsu_valid = ($urandom_range(0, 99) < 60);
        bus.lsu_rd    = 5'($urandom_range(0, 31));
        bus.lsu_data  = $urandom;
      end
      bus.issue_valid = ($urandom_range(0, 1) == 1);
      bus.issue_rd    = ($urandom_range(0, 3) == 0) ? m_reg : 5'($urandom_range(0, 31));
      bus.chk_rs1     = ($urandom_range(0, 3) == 0) ? m_reg : 5'($urandom_range(0, 31));
      bus.chk_rs2     = 5'($urandom_range(0, 31));

      @(negedge clk);
      exp_ar = bus.alu_valid && (!bus.lsu_valid || m_next_alu);
      exp_lr = bus.lsu_valid && (!bus.alu_valid || !m_next_alu);
      e_rs1  = (bus.chk_rs1 == 5'd0) ? 1'b0 : m_busy[bus.chk_rs1];
      e_rs2  = (bus.chk_rs2 == 5'd0) ? 1'b0 : m_busy[bus.chk_rs2];
      check("rnd_alu_ready", bus.alu_ready, exp_ar);
      check("rnd_lsu_ready", bus.lsu_ready, exp_lr);
      check("rnd_rs1_busy",  bus.rs1_busy,  e_rs1);
      check("rnd_rs2_busy",  bus.rs2_busy,  e_rs2);

      // Next model state from the transaction rules.
      n_we = 1'b0; n_reg = m_reg; n_data = m_data; n_next_alu = m_next_alu;
      if (exp_ar) begin
        n_we = (bus.alu_rd != 0); n_reg = bus.alu_rd; n_data = bus.alu_data;
        n_next_alu = 1'b0;
      end else if (exp_lr) begin
        n_we = (bus.lsu_rd != 0); n_reg = bus.lsu_rd; n_data = bus.lsu_data;
        n_next_alu = 1'b1;
      end
      n_cnt = m_cnt;
      if (bus.alu_valid && bus.lsu_valid && m_cnt < CNT_MAX) n_cnt = m_cnt + 1;
      n_busy = m_busy;
      if (m_we) n_busy[m_reg] = 1'b0;
      if (bus.issue_valid && bus.issue_rd != 0) n_busy[bus.issue_rd] = 1'b1;
      alu_hold = bus.alu_valid && !exp_ar;
      lsu_hold = bus.lsu_valid && !exp_lr;

      tick();
      m_we = n_we; m_reg = n_reg; m_data = n_data; m_next_alu = n_next_alu;
      m_cnt = n_cnt; m_busy = n_busy;
      check("rnd_rd_we",     bus.rd_we,        m_we);
      check("rnd_writeReg",  bus.writeReg,     m_reg);
      check("rnd_writeData", bus.writeData,    m_data);
      check("rnd_cnt",       bus.conflict_cnt, m_cnt);
      $display("rnd %0d: ar=%0b lr=%0b we=%0b reg=%0d data=%h cnt=%0d",
               c, exp_ar, exp_lr, bus.rd_we, bus.writeReg, bus.writeData,
               bus.conflict_cnt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter: XLEN, 32, data width of regfile write port.
REQ-002 Parameter: CNT_W, 16, width of conflict counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 alu_valid  input  1  ALU writeback request.
REQ-006 alu_rd  input  5  ALU destination register.
REQ-007 alu_data  input  XLEN  ALU result.
REQ-008 alu_ready  output  1  ALU request accepted this cycle.
REQ-009 lsu_valid  input  1  load-unit writeback request.
REQ-010 lsu_rd  input  5  load destination register.
REQ-011 lsu_data  input  XLEN  load result.
REQ-012 lsu_ready  output  1  load request accepted this cycle.
REQ-013 rd_we  output  1  regfile write enable.
REQ-014 writeReg  output  5  regfile write address.
REQ-015 writeData  output  XLEN  regfile write data.
REQ-016 issue_valid  input  1  instruction issued with destination issue_rd.
REQ-017 issue_rd  input  5  destination register to mark busy.
REQ-018 chk_rs1, chk_rs2  input  5 each  source registers to hazard-check.
REQ-019 rs1_busy, rs2_busy  output  1 each  source has pending writeback.
REQ-020 conflict_cnt  output  CNT_W  count of cycles with both requesters valid.

Function
REQ-021 Transfer occurs on a source when valid and ready are both high at a rising edge.
REQ-022 alu_ready/lsu_ready are combinational from valids and arbitration pointer; at most one high per cycle.
REQ-023 Only one source valid: that source's ready is high.
REQ-024 Both valid: round-robin; pointer value ALU grants ALU, value LSU grants LSU.
REQ-025 Pointer flips to the other source after every granted transfer; unchanged when no transfer.
REQ-026 A source not granted holds valid, rd, data stable until accepted; arbiter does not buffer unaccepted requests.
REQ-027 Accepted transfer registers rd_we=1, writeReg=rd, writeData=data at the same edge (1-cycle latency).
REQ-028 Accepted transfer with rd=0: ready still asserted, registered rd_we=0, writeReg/writeData still updated.
REQ-029 Cycle after no transfer: rd_we=0; writeReg/writeData hold last values.
REQ-030 Sustained throughput: one write per cycle.
REQ-031 Scoreboard: 32 busy bits; busy[0] constantly 0.
REQ-032 issue_valid with issue_rd!=0 sets busy[issue_rd] at next edge.
REQ-033 rd_we=1 clears busy[writeReg] at the edge where the regfile commits the write.
REQ-034 Set and clear of same register at same edge: set wins (busy stays 1).
REQ-035 rsN_busy = busy[chk_rsN], combinational, no bypass; chk_rsN=0 yields 0.
REQ-036 conflict_cnt increments by 1 each cycle both valids are high; saturates at all-ones.

Reset
REQ-037 rst high forces immediately: rd_we=0, writeReg=0, writeData=0, all busy=0, pointer=ALU, conflict_cnt=0.
REQ-038 While rst high, alu_ready=lsu_ready=0 and no transfer is accepted.
REQ-039 Reset mid-operation drops any registered write (rd_we=0) and clears all busy bits; first post-reset conflict grants ALU.

Verification
REQ-040 Reset then alu_valid=1, alu_rd=5, alu_data=A5A5A5A5 one cycle -> next cycle rd_we=1, writeReg=5, writeData=A5A5A5A5; then rd_we=0.
REQ-041 Both valid for 2 cycles (alu_rd=10/12345678, lsu_rd=7/DEADBEEF) after reset -> ALU written first, LSU second; conflict_cnt=2.
REQ-042 lsu_valid=1, lsu_rd=0, lsu_data=FFFFFFFF -> lsu_ready=1, following cycle rd_we=0.
REQ-043 issue_valid, issue_rd=3; chk_rs1=3 -> rs1_busy=1 until cycle after ALU writeback to x3 appears on rd_we, then 0.
REQ-044 issue_rd=3 and rd_we=1/writeReg=3 in same cycle -> rs1_busy (chk_rs1=3) remains 1.
REQ-045 Assert rst while rd_we=1 and busy[3]=1 -> rd_we=0, rs1_busy=0, conflict_cnt=0 without waiting for a clock edge.
